bitonic_seq_sort: RTL and testbench
===================================

BITONIC_SEQ_SORT -- requirements
Module: bitonic_seq_sort

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  in_data holds a valid element.
REQ-005 in_data  input  8  unsigned element, loaded serially.
REQ-006 in_ready  output  1  block accepts an element this cycle.
REQ-007 out_valid  output  1  out_data holds a valid sorted element.
REQ-008 out_data  output  8  sorted element, streamed serially.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 busy  output  1  high in SORT and OUT states.

Function
REQ-011 The FSM SHALL have exactly three states: LOAD, SORT and OUT.
REQ-012 The block SHALL hold an 8-entry by 8-bit register array slot[0..7] and a 3-bit index counter idx.
REQ-013 In LOAD, in_ready SHALL be 1, out_valid 0 and busy 0.
REQ-014 In LOAD, each handshake (in_valid and in_ready) SHALL write in_data to slot[idx] and increment idx.
REQ-015 The accept with idx==7 SHALL wrap idx to 0, clear stage counter st, and move to SORT.
REQ-016 SORT SHALL last exactly 6 cycles, with one network stage applied per edge, in this order of (k,j): (2,1), (4,2), (4,1), (8,4), (8,2), (8,1).
REQ-017 Within each SORT stage, every pair (i, i^j) with i^j>i SHALL be compare-exchanged simultaneously.
REQ-018 A pair SHALL be ascending when (i&k)==0 and descending otherwise; at k=8 all pairs are ascending.
REQ-019 Comparisons SHALL be unsigned 8-bit; equal values SHALL NOT be swapped.
REQ-020 The edge applying stage (8,1) SHALL move the FSM to OUT with idx=0.
REQ-021 First out_valid SHALL be 6 cycles after the cycle in which the 8th input was accepted.
REQ-022 In OUT, out_valid SHALL be 1, in_ready 0, and out_data = slot[idx] (combinational from registers).
REQ-023 In OUT, out_data SHALL stay stable while out_ready is 0.
REQ-024 Each OUT handshake SHALL increment idx; the handshake at idx==7 SHALL return the FSM to LOAD with idx=0.
REQ-025 A new load SHALL be accepted in the cycle after the last output handshake (no bubble beyond that).
REQ-026 in_valid outside LOAD SHALL be ignored, and no data SHALL be written.
REQ-027 out_ready outside OUT SHALL be ignored.

Reset
REQ-028 When rst_n==0 at a clock edge, the FSM SHALL go to LOAD, with idx=0, st=0 and all slots 0.
REQ-029 The reset values of the outputs SHALL be: in_ready=1, out_valid=0, out_data=8'h00, busy=0.
REQ-030 A reset asserted mid-LOAD, mid-SORT or mid-OUT SHALL discard all partial data, and no further outputs SHALL be produced for that set.

Configuration
REQ-031 Macro BITONIC_SEQ_DESCEND_EN, when defined, SHALL invert the stage-(8,*) direction to descending, so the stream is largest first.
REQ-032 When BITONIC_SEQ_DESCEND_EN is undefined, the output SHALL be ascending (smallest first).
REQ-033 When BITONIC_SEQ_DESCEND_EN is defined, stages with k<8 SHALL be unchanged.
REQ-034 Latency and handshake SHALL be identical in both builds.

Verification
REQ-035 Load 8'h07,06,05,04,03,02,01,00 back-to-back, with out_ready=1 -> out_valid rises 6 cycles after the last accept; out_data = 00,01,...,07 on consecutive cycles; then in_ready=1.
REQ-036 Load 8'hFF,00,80,7F,01,FE,80,00, with out_ready toggling 1/0 -> output 00,00,01,7F,80,80,FE,FF, with each value held while out_ready=0.
REQ-037 Drive in_valid gaps (valid on alternate cycles) with all inputs 8'h5A -> 8 outputs of 5A; SORT still exactly 6 cycles.
REQ-038 Assert rst_n=0 for 1 cycle during the 3rd SORT cycle -> next cycle LOAD, in_ready=1, out_valid=0; a fresh load of 1..8 sorts correctly.
REQ-039 With in_valid held 1 during SORT/OUT -> no slot corruption; the output matches the first set only.
REQ-040 With BITONIC_SEQ_DESCEND_EN defined, load 00..07 -> output 07,06,...,00.

Source files
------------

// File: rtl/bitonic_seq_sort.sv
// Serial-in / serial-out 8-element bitonic sorter: load 8 bytes, run 6 network stages, stream out.
// Define BITONIC_SEQ_DESCEND_EN to make the final merge descending (largest element first).
module bitonic_seq_sort (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] st_q, st_d;
  logic [7:0] slot_q [8];
  logic [7:0] slot_d [8];
  logic [7:0] net    [8];
  logic [3:0] stage_k, stage_j;

  always_comb begin
    stage_k = 4'd8;
    stage_j = 4'd1;
    case (st_q)
      3'd0:    begin stage_k = 4'd2; stage_j = 4'd1; end
      3'd1:    begin stage_k = 4'd4; stage_j = 4'd2; end
      3'd2:    begin stage_k = 4'd4; stage_j = 4'd1; end
      3'd3:    begin stage_k = 4'd8; stage_j = 4'd4; end
      3'd4:    begin stage_k = 4'd8; stage_j = 4'd2; end
      default: begin stage_k = 4'd8; stage_j = 4'd1; end
    endcase
  end

  // One compare-exchange stage; pairs within a stage are disjoint, so all swaps are independent.
  // For k=8 the (i & k[2:0]) term is always zero, giving the all-ascending final merge.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) net[i] = slot_q[i];
    for (int unsigned i = 0; i < 8; i++) begin
      logic [2:0] ii;
      logic [2:0] pi;
      logic       asc;
      ii  = 3'(i);
      pi  = ii ^ stage_j[2:0];
      asc = ((ii & stage_k[2:0]) == 3'b000);
`ifdef BITONIC_SEQ_DESCEND_EN
      if (stage_k[3]) asc = 1'b0;
`endif
      if (pi > ii) begin
        if (asc ? (slot_q[ii] > slot_q[pi]) : (slot_q[ii] < slot_q[pi])) begin
          net[ii] = slot_q[pi];
          net[pi] = slot_q[ii];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    st_d    = st_q;
    slot_d  = slot_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          slot_d[idx_q] = in_data;
          idx_d         = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            st_d    = '0;
            state_d = SORT;
          end
        end
      end
      SORT: begin
        slot_d = net;
        st_d   = st_q + 3'd1;
        if (st_q == 3'd5) begin
          st_d    = '0;
          idx_d   = '0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      st_q    <= '0;
      for (int unsigned i = 0; i < 8; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
      for (int unsigned i = 0; i < 8; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != LOAD);
  assign out_data  = (state_q == OUT) ? slot_q[idx_q] : '0;

endmodule

// File: tb/tb_bitonic_seq_sort.sv
// Scoreboard bench for bitonic_seq_sort: stimulus pushes the sorted reference set, a negedge monitor pops and compares.
module tb_bitonic_seq_sort;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  bitonic_seq_sort dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: handshake seen at negedge completes at the following posedge.
  initial begin
    logic       hold_pend;
    logic [7:0] hold_val;
    hold_pend = 1'b0;
    hold_val  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else if (out_valid) begin
        if (hold_pend) check("out_hold", out_data, hold_val);
        if (out_ready) begin
          hold_pend = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out actual=%0h required=none", out_data);
          end else begin
            check("out_data", out_data, exp_q.pop_front());
          end
        end else begin
          hold_pend = 1'b1;
          hold_val  = out_data;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input logic [7:0] d [8]);
    logic [7:0] s [$];
    for (int i = 0; i < 8; i++) s.push_back(d[i]);
    s.sort();
`ifdef BITONIC_SEQ_DESCEND_EN
    s.reverse();
`endif
    for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
  endtask

  task automatic load_set(input logic [7:0] d [8], input int gap, input bit noise);
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_data   = d[i];
      out_ready = 1'($urandom);
      check("in_ready_load", in_ready, 1);
      step();
      if (i < 7) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          in_data = 8'($urandom);
          step();
        end
      end
    end
    in_valid = noise;
    in_data  = 8'($urandom);
    push_model(d);
  endtask

  task automatic sort_latency(input bit noise);
    int n = 0;
    while (!out_valid && n < 20) begin
      check("busy_sort", busy, 1);
      if (noise) in_data = 8'($urandom);
      out_ready = 1'($urandom);
      step();
      n++;
    end
    check("sort_cycles", n, 6);
  endtask

  task automatic drain(input bit toggle, input bit noise);
    int n = 0;
    out_ready = toggle ? 1'b0 : 1'b1;
    while (busy && n < 100) begin
      check("in_ready_out", in_ready, 0);
      out_ready = toggle ? ~out_ready : 1'b1;
      if (noise) in_data = 8'($urandom);
      step();
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("drain_timeout", (n < 100) ? 1 : 0, 1);
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_set(input logic [7:0] d [8], input int gap, input bit toggle, input bit noise);
    load_set(d, gap, noise);
    sort_latency(noise);
    drain(toggle, noise);
  endtask

  initial begin
    logic [7:0] d [8];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    d = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    run_set(d, 0, 1'b0, 1'b0);

    d = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h80, 8'h00};
    run_set(d, 0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) d[i] = 8'h5A;
    run_set(d, 1, 1'b0, 1'b0);

    // Reset during the third SORT cycle discards the set.
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
    load_set(d, 0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    check("midsort_rst_in_ready", in_ready, 1);
    check("midsort_rst_out_valid", out_valid, 0);
    check("midsort_rst_busy", busy, 0);
    out_ready = 1'b1;
    repeat (10) step();
    out_ready = 1'b0;
    d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_set(d, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
    run_set(d, 0, 1'b1, 1'b1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom_range(0, 255));
      run_set(d, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
    end

    d = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    run_set(d, 0, 1'b0, 1'b0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
